// File: rtl/retire_trace_pkg.sv
// rtl/retire_trace_pkg.sv - shared constants and trace-entry layout for the retire trace buffer
// Entry layout, LSB first: pc, opcode, pipe, seq, then time when RETIRE_TRACE_TIMESTAMP_EN is defined.
package retire_trace_pkg;

  localparam logic [31:0] MARKER_VALUE = 32'hDEADBEEF;
  localparam int          DROP_W       = 8;

  localparam int PC_W     = 32;
  localparam int OPC_W    = 32;
  localparam int PIPE_W   = 1;
  localparam int TIME_W   = 32;

  localparam int PC_LSB   = 0;
  localparam int OPC_LSB  = PC_LSB + PC_W;
  localparam int PIPE_LSB = OPC_LSB + OPC_W;
  localparam int SEQ_LSB  = PIPE_LSB + PIPE_W;

  function automatic int time_lsb(input int cnt_w);
    return SEQ_LSB + cnt_w;
  endfunction

  function automatic int entry_w(input int cnt_w);
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    return SEQ_LSB + cnt_w + TIME_W;
`else
    return SEQ_LSB + cnt_w;
`endif
  endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// rtl/retire_trace_buffer_if.sv - trace read port: head entry presented with valid/accept
// trace_time_o exists only when RETIRE_TRACE_TIMESTAMP_EN is defined.
interface retire_trace_buffer_if #(
  parameter int CNT_W = 16
);
  logic             trace_valid_o;
  logic             trace_accept_i;
  logic [31:0]      trace_pc_o;
  logic [31:0]      trace_opcode_o;
  logic             trace_pipe_o;
  logic [CNT_W-1:0] trace_seq_o;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
  logic [31:0]      trace_time_o;
`endif

  modport master (
    output trace_valid_o, trace_pc_o, trace_opcode_o, trace_pipe_o, trace_seq_o,
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    output trace_time_o,
`endif
    input  trace_accept_i
  );

  modport slave (
    input  trace_valid_o, trace_pc_o, trace_opcode_o, trace_pipe_o, trace_seq_o,
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    input  trace_time_o,
`endif
    output trace_accept_i
  );
endinterface

// File: rtl/retire_trace_fifo2w.sv
// rtl/retire_trace_fifo2w.sv - two-write/one-read FIFO with extra pointer bit for full/empty
// Callers must gate pushes with free_o; free_o ignores a same-cycle pop.
module retire_trace_fifo2w #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push0_i,
  input  logic [W-1:0]  data0_i,
  input  logic          push1_i,
  input  logic [W-1:0]  data1_i,
  input  logic          pop_i,
  output logic [PW-1:0] free_o,
  output logic          valid_o,
  output logic [W-1:0]  head_o
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW-1:0] w_used;
  logic [PW-1:0] w_wp1;
  logic          w_pop;

  assign w_used  = r_wp - r_rp;
  assign free_o  = PW'(DEPTH) - w_used;
  assign valid_o = (w_used != '0);
  assign head_o  = r_mem[r_rp[AW-1:0]];
  assign w_pop   = pop_i && valid_o;
  // pipe1 lands right after pipe0 when both push, otherwise in pipe0's slot
  assign w_wp1   = r_wp + PW'(push0_i);

  always_ff @(posedge clk_i) begin
    if (push0_i) r_mem[r_wp[AW-1:0]]  <= data0_i;
    if (push1_i) r_mem[w_wp1[AW-1:0]] <= data1_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= w_wp1 + PW'(push1_i);
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end
endmodule

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - filters, sequences and buffers dual-pipe retirement events
// Optional per-entry cycle timestamp: define RETIRE_TRACE_TIMESTAMP_EN.
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] MARKER_ADDR = 32'h80009030
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_valid_i,
  input  logic [31:0]       p0_pc_i,
  input  logic [31:0]       p0_opcode_i,
  input  logic [4:0]        p0_rd_idx_i,
  input  logic [4:0]        p0_ra_idx_i,
  input  logic [4:0]        p0_rb_idx_i,
  input  logic              p1_valid_i,
  input  logic [31:0]       p1_pc_i,
  input  logic [31:0]       p1_opcode_i,
  input  logic [4:0]        p1_rd_idx_i,
  input  logic [4:0]        p1_ra_idx_i,
  input  logic [4:0]        p1_rb_idx_i,
  input  logic              cfg_enable_i,
  input  logic [4:0]        cfg_watch_idx_i,
  input  logic [CNT_W-1:0]  cfg_full_after_i,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic [3:0]        mem_d_wr_i,
  retire_trace_buffer_if.master trace,
  output logic [CNT_W-1:0]  instr_count_o,
  output logic [DROP_W-1:0] drop_count_o,
  output logic              done_o
);
  localparam int EW = entry_w(CNT_W);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]  r_count;
  logic [DROP_W-1:0] r_drop;
  logic              r_done;
  logic [CNT_W+1:0]  w_seq0_raw, w_seq1_raw, w_cnt_raw;
  logic [CNT_W-1:0]  w_seq0, w_seq1;
  logic              w_keep0, w_keep1, w_push0, w_push1, w_marker, w_valid;
  logic [1:0]        w_lost;
  logic [DROP_W:0]   w_drop_sum;
  logic [PW-1:0]     w_free;
  logic [EW-1:0]     w_data0, w_data1, w_head;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W+1:0] x);
    return (x[CNT_W+1:CNT_W] != 2'b00) ? '1 : x[CNT_W-1:0];
  endfunction

  function automatic logic watch_hit(input logic [4:0] w, rd, ra, rb);
    return (w != 5'd0) && (w == rd || w == ra || w == rb);
  endfunction

  assign w_seq0_raw = {2'b00, r_count} + {{(CNT_W+1){1'b0}}, 1'b1};
  assign w_seq1_raw = w_seq0_raw + {{(CNT_W+1){1'b0}}, p0_valid_i};
  assign w_cnt_raw  = {2'b00, r_count} + {{CNT_W{1'b0}}, {1'b0, p0_valid_i} + {1'b0, p1_valid_i}};
  assign w_seq0     = sat(w_seq0_raw);
  assign w_seq1     = sat(w_seq1_raw);

  assign w_keep0 = p0_valid_i && cfg_enable_i && !r_done &&
                   (w_seq0 >= cfg_full_after_i ||
                    watch_hit(cfg_watch_idx_i, p0_rd_idx_i, p0_ra_idx_i, p0_rb_idx_i));
  assign w_keep1 = p1_valid_i && cfg_enable_i && !r_done &&
                   (w_seq1 >= cfg_full_after_i ||
                    watch_hit(cfg_watch_idx_i, p1_rd_idx_i, p1_ra_idx_i, p1_rb_idx_i));

  // pipe0 claims the first free slot; pipe1 needs a second one if pipe0 is also kept
  assign w_push0    = w_keep0 && (w_free != '0);
  assign w_push1    = w_keep1 && (w_free >= (w_keep0 ? PW'(2) : PW'(1)));
  assign w_lost     = {1'b0, w_keep0 && !w_push0} + {1'b0, w_keep1 && !w_push1};
  assign w_drop_sum = {1'b0, r_drop} + {{(DROP_W-1){1'b0}}, w_lost};
  assign w_marker   = (mem_d_wr_i == 4'hF) && (mem_d_addr_i == MARKER_ADDR) &&
                      (mem_d_data_wr_i == MARKER_VALUE);

`ifdef RETIRE_TRACE_TIMESTAMP_EN
  localparam int TL = time_lsb(CNT_W);
  logic [31:0] r_time;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_time <= '0;
    else       r_time <= r_time + 32'd1;
  end

  assign w_data0 = {r_time, w_seq0, 1'b0, p0_opcode_i, p0_pc_i};
  assign w_data1 = {r_time, w_seq1, 1'b1, p1_opcode_i, p1_pc_i};
  assign trace.trace_time_o = w_valid ? w_head[TL +: TIME_W] : '0;
`else
  assign w_data0 = {w_seq0, 1'b0, p0_opcode_i, p0_pc_i};
  assign w_data1 = {w_seq1, 1'b1, p1_opcode_i, p1_pc_i};
`endif

  retire_trace_fifo2w #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push0_i (w_push0),
    .data0_i (w_data0),
    .push1_i (w_push1),
    .data1_i (w_data1),
    .pop_i   (trace.trace_accept_i),
    .free_o  (w_free),
    .valid_o (w_valid),
    .head_o  (w_head)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
      r_drop  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_count <= sat(w_cnt_raw);
      r_drop  <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
      r_done  <= r_done || w_marker;
    end
  end

  // empty FIFO presents zeros rather than stale storage
  assign trace.trace_valid_o  = w_valid;
  assign trace.trace_pc_o     = w_valid ? w_head[PC_LSB +: PC_W] : '0;
  assign trace.trace_opcode_o = w_valid ? w_head[OPC_LSB +: OPC_W] : '0;
  assign trace.trace_pipe_o   = w_valid && w_head[PIPE_LSB];
  assign trace.trace_seq_o    = w_valid ? w_head[SEQ_LSB +: CNT_W] : '0;
  assign instr_count_o        = r_count;
  assign drop_count_o         = r_drop;
  assign done_o               = r_done;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - directed table-driven bench for retire_trace_buffer
module tb_retire_trace_buffer;
  localparam logic [31:0] MADDR = 32'h80009030;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_valid, p1_valid;
  logic [31:0] p0_pc, p0_opc, p1_pc, p1_opc;
  logic [4:0]  p0_rd, p0_ra, p0_rb, p1_rd, p1_ra, p1_rb;
  logic        cfg_en;
  logic [4:0]  cfg_watch;
  logic [15:0] cfg_full;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_wr;
  logic [15:0] icount;
  logic [7:0]  dcount;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;

  retire_trace_buffer_if #(.CNT_W(16)) u_if ();

  retire_trace_buffer u_dut (
    .clk_i(clk), .rst_i(rst),
    .p0_valid_i(p0_valid), .p0_pc_i(p0_pc), .p0_opcode_i(p0_opc),
    .p0_rd_idx_i(p0_rd), .p0_ra_idx_i(p0_ra), .p0_rb_idx_i(p0_rb),
    .p1_valid_i(p1_valid), .p1_pc_i(p1_pc), .p1_opcode_i(p1_opc),
    .p1_rd_idx_i(p1_rd), .p1_ra_idx_i(p1_ra), .p1_rb_idx_i(p1_rb),
    .cfg_enable_i(cfg_en), .cfg_watch_idx_i(cfg_watch), .cfg_full_after_i(cfg_full),
    .mem_d_addr_i(m_addr), .mem_d_data_wr_i(m_data), .mem_d_wr_i(m_wr),
    .trace(u_if),
    .instr_count_o(icount), .drop_count_o(dcount), .done_o(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit v0; bit v1; bit acc; bit mark;
    bit e_valid; int e_seq; bit e_pipe; int e_cnt; bit e_done;
  } vec_t;

  typedef struct { int seq; logic [31:0] pc; logic [31:0] opc; bit pipe; } rec_t;

  vec_t tbl[17];
  rec_t got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_valid = 0; p1_valid = 0;
    p0_pc = 0; p0_opc = 0; p1_pc = 0; p1_opc = 0;
    p0_rd = 0; p0_ra = 0; p0_rb = 0; p1_rd = 0; p1_ra = 0; p1_rb = 0;
    m_addr = 0; m_data = 0; m_wr = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic dual(input int n);
    for (int i = 0; i < n; i++) begin
      p0_valid = 1; p1_valid = 1;
      step();
    end
    idle();
  endtask

  task automatic drain(input int max_cycles);
    got.delete();
    u_if.trace_accept_i = 1;
    for (int i = 0; i < max_cycles; i++) begin
      if (u_if.trace_valid_o)
        got.push_back('{int'(u_if.trace_seq_o), u_if.trace_pc_o, u_if.trace_opcode_o, u_if.trace_pipe_o});
      step();
    end
  endtask

  initial begin
    idle();
    cfg_en = 1; cfg_watch = 0; cfg_full = 0;
    u_if.trace_accept_i = 0;
    step();
    step();
    rst = 0;

    chk("reset_valid", u_if.trace_valid_o, 0);
    chk("reset_count", icount, 0);
    chk("reset_drop", dcount, 0);
    chk("reset_done", done, 0);
    chk("reset_seq", u_if.trace_seq_o, 0);

    // dual issue, head stability, empty accept, marker
    tbl[0]  = '{1,1,1,0, 1, 1,0, 2,0};
    tbl[1]  = '{1,1,1,0, 1, 2,1, 4,0};
    tbl[2]  = '{1,1,1,0, 1, 3,0, 6,0};
    tbl[3]  = '{1,1,1,0, 1, 4,1, 8,0};
    tbl[4]  = '{0,0,1,0, 1, 5,0, 8,0};
    tbl[5]  = '{0,0,1,0, 1, 6,1, 8,0};
    tbl[6]  = '{0,0,1,0, 1, 7,0, 8,0};
    tbl[7]  = '{0,0,1,0, 1, 8,1, 8,0};
    tbl[8]  = '{0,0,1,0, 0, 0,0, 8,0};
    tbl[9]  = '{0,1,1,0, 1, 9,1, 9,0};
    tbl[10] = '{1,0,0,0, 1, 9,1,10,0};
    tbl[11] = '{0,0,1,0, 1,10,0,10,0};
    tbl[12] = '{0,0,1,0, 0, 0,0,10,0};
    tbl[13] = '{1,0,0,1, 1,11,0,11,1};
    tbl[14] = '{1,1,0,0, 1,11,0,13,1};
    tbl[15] = '{0,0,1,0, 0, 0,0,13,1};
    tbl[16] = '{0,0,1,0, 0, 0,0,13,1};

    for (int i = 0; i < 17; i++) begin
      idle();
      p0_valid = tbl[i].v0;
      p1_valid = tbl[i].v1;
      u_if.trace_accept_i = tbl[i].acc;
      if (tbl[i].mark) begin
        m_addr = MADDR; m_data = 32'hDEADBEEF; m_wr = 4'hF;
      end
      step();
      chk($sformatf("tbl%0d_valid", i), u_if.trace_valid_o, tbl[i].e_valid);
      chk($sformatf("tbl%0d_seq", i), u_if.trace_seq_o, tbl[i].e_seq);
      chk($sformatf("tbl%0d_pipe", i), u_if.trace_pipe_o, tbl[i].e_pipe);
      chk($sformatf("tbl%0d_count", i), icount, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_drop", i), dcount, 0);
    end
    idle();

    // watch register and full-capture threshold
    do_reset();
    cfg_watch = 5'd31; cfg_full = 16'd70;
    u_if.trace_accept_i = 1;
    got.delete();
    for (int i = 1; i <= 100; i++) begin
      p0_valid = 1;
      p0_pc = i * 4;
      p0_opc = 32'hA5A50000 | i;
      p0_rd = (i == 5) ? 5'd31 : 5'd1;
      p0_ra = (i == 40) ? 5'd31 : 5'd2;
      p0_rb = 5'd3;
      step();
      if (u_if.trace_valid_o)
        got.push_back('{int'(u_if.trace_seq_o), u_if.trace_pc_o, u_if.trace_opcode_o, u_if.trace_pipe_o});
    end
    idle();
    chk("watch_count", icount, 100);
    begin
      int exp_q[$];
      exp_q.push_back(5);
      exp_q.push_back(40);
      for (int s = 70; s <= 100; s++) exp_q.push_back(s);
      chk("watch_n", got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
        chk($sformatf("watch%0d_seq", k), got[k].seq, exp_q[k]);
        chk($sformatf("watch%0d_pc", k), got[k].pc, exp_q[k] * 4);
        chk($sformatf("watch%0d_opc", k), got[k].opc, 32'hA5A50000 | exp_q[k]);
        chk($sformatf("watch%0d_pipe", k), got[k].pipe, 0);
      end
    end
    step();
    chk("watch_empty", u_if.trace_valid_o, 0);

    // overflow with accept low, then pop-does-not-free-space, then drain
    cfg_watch = 0; cfg_full = 0;
    u_if.trace_accept_i = 0;
    do_reset();
    dual(10);
    chk("ovf_drop", dcount, 4);
    chk("ovf_count", icount, 20);
    chk("ovf_head_seq", u_if.trace_seq_o, 1);
    chk("ovf_head_pipe", u_if.trace_pipe_o, 0);
    u_if.trace_accept_i = 1;
    dual(1);
    chk("ovf_pop_drop", dcount, 6);
    chk("ovf_pop_count", icount, 22);
    chk("ovf_pop_head", u_if.trace_seq_o, 2);
    drain(20);
    chk("ovf_drain_n", got.size(), 15);
    for (int k = 0; k < got.size(); k++) begin
      chk($sformatf("ovf%0d_seq", k), got[k].seq, k + 2);
      chk($sformatf("ovf%0d_pipe", k), got[k].pipe, (k + 1) % 2);
    end
    chk("ovf_empty", u_if.trace_valid_o, 0);

    // single free slot with both pipes kept: pipe0 wins
    u_if.trace_accept_i = 0;
    do_reset();
    dual(7);
    p0_valid = 1;
    step();
    dual(1);
    chk("short_drop", dcount, 1);
    chk("short_count", icount, 17);
    drain(20);
    chk("short_n", got.size(), 16);
    for (int k = 0; k < got.size(); k++)
      chk($sformatf("short%0d_seq", k), got[k].seq, k + 1);
    if (got.size() == 16) chk("short_last_pipe", got[15].pipe, 0);

    // drop counter saturation
    u_if.trace_accept_i = 0;
    do_reset();
    dual(136);
    chk("sat_drop", dcount, 255);
    chk("sat_count", icount, 272);

    // partial strobe to marker address
    do_reset();
    m_addr = MADDR; m_data = 32'hDEADBEEF; m_wr = 4'h3;
    step();
    chk("partial_done0", done, 0);
    idle();
    step();
    chk("partial_done1", done, 0);

    // reset mid-stream with entries buffered and done set
    do_reset();
    dual(2);
    p0_valid = 1;
    m_addr = MADDR; m_data = 32'hDEADBEEF; m_wr = 4'hF;
    step();
    idle();
    chk("mid_count", icount, 5);
    chk("mid_done", done, 1);
    chk("mid_valid", u_if.trace_valid_o, 1);
    p0_valid = 1; p1_valid = 1;
    rst = 1;
    step();
    rst = 0;
    idle();
    chk("rst_valid", u_if.trace_valid_o, 0);
    chk("rst_count", icount, 0);
    chk("rst_drop", dcount, 0);
    chk("rst_done", done, 0);
    u_if.trace_accept_i = 1;
    step();
    chk("rst_after_valid", u_if.trace_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
